mcb_ref_arb: RTL and testbench

//  Auto-refresh scheduler and command-sequencer arbiter for the sdrc_lite MCB back-end.

---
 rtl/mcb_ref_arb.sv | 183 ++++++++++++++++++
 tb/tb_mcb_ref_arb.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mcb_ref_arb.sv
// Purpose     : auto-refresh scheduler plus one-owner arbiter for the MCB command sequencer.
// Latency     : a grant (u_gnt / r_req) appears one cycle after the IDLE decision; one IDLE cycle follows each release.
// Backpressure: the user path waits on u_req until the sequencer is free; refresh demand accumulates in pend_cnt up to PEND_MAX.
//
// Ports
//   mcb_clk     controller clock
//   mcb_rst_n   asynchronous active-low reset
//   mcb_sclr_n  synchronous active-low clear, same effect as reset
//   i_ready     initialization complete (level); gates the refresh interval counter and the arbiter
//   u_req       user access request (level, held until u_gnt)
//   u_gnt       user owns the sequencer; held until u_done
//   u_done      1-cycle pulse, user access finished with all banks precharged
//   r_req       request the sequencer to issue one AUTO REFRESH; held until r_ack
//   r_ack       1-cycle pulse, REF issued and tRFC elapsed
//   ref_urgent  pend_cnt >= URG_TH
//   ref_ovf     sticky: a refresh tick arrived with pend_cnt already at PEND_MAX
//   pend_cnt    refreshes currently owed
module mcb_ref_arb #(
   parameter int unsigned REFI_CNT = 780,
   parameter int unsigned REFI_W   = 11,
   parameter int unsigned PEND_MAX = 8,
   parameter int unsigned PEND_W   = 4,
   parameter int unsigned URG_TH   = 6
) (
   input  logic              mcb_clk,
   input  logic              mcb_rst_n,
   input  logic              mcb_sclr_n,
   input  logic              i_ready,
   input  logic              u_req,
   output logic              u_gnt,
   input  logic              u_done,
   output logic              r_req,
   input  logic              r_ack,
   output logic              ref_urgent,
   output logic              ref_ovf,
   output logic [PEND_W-1:0] pend_cnt
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_USER = 2'd1;
   localparam logic [1:0] ST_REF  = 2'd2;

   localparam logic [REFI_W-1:0] REFI_LAST = REFI_W'(REFI_CNT - 1);
   localparam logic [PEND_W-1:0] PEND_SAT  = PEND_W'(PEND_MAX);
   localparam logic [PEND_W-1:0] URG_LVL   = PEND_W'(URG_TH);

   logic [REFI_W-1:0] refi_cnt_q, refi_cnt_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              ovf_q, ovf_d;
   logic [1:0]        state_q, state_d;
   logic              u_gnt_q, u_gnt_d;
   logic              r_req_q, r_req_d;

   logic              tick;
   logic              ref_done;
   logic              urgent;

   // ------------------------------------------------------------------
   // Refresh interval counter: parked at 0 until init completes, then
   // free-runs 0..REFI_CNT-1; the last count is the refresh tick.
   // ------------------------------------------------------------------
   assign tick = i_ready & (refi_cnt_q == REFI_LAST);

   always_comb begin
      refi_cnt_d = refi_cnt_q;
      if (!i_ready) begin
         refi_cnt_d = '0;
      end else if (tick) begin
         refi_cnt_d = '0;
      end else begin
         refi_cnt_d = refi_cnt_q + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Owed-refresh accounting. An r_ack only counts while a refresh is
   // actually granted; a stray pulse elsewhere must not retire debt.
   // A tick landing together with a retire nets to zero, so nothing is
   // lost and the overflow flag stays untouched in that case.
   // ------------------------------------------------------------------
   assign ref_done = r_ack & (state_q == ST_REF);
   assign urgent   = (pend_q >= URG_LVL);

   always_comb begin
      pend_d = pend_q;
      ovf_d  = ovf_q;
      case ({tick, ref_done})
         2'b10: begin
            if (pend_q == PEND_SAT) begin
               ovf_d = 1'b1;
            end else begin
               pend_d = pend_q + 1'b1;
            end
         end
         2'b01: begin
            // A REF grant is only made with pend_q != 0, so this guard
            // never fires in practice; it keeps the counter from wrapping.
            if (pend_q != '0) begin
               pend_d = pend_q - 1'b1;
            end
         end
         default: begin
            pend_d = pend_q;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Sequencer ownership. Decisions are taken in IDLE only, so every
   // release is followed by one IDLE cycle before the next grant. Once
   // granted, the user is never preempted; urgency only changes which
   // owner wins the next IDLE decision.
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (i_ready) begin
               if (urgent) begin
                  state_d = ST_REF;
               end else if (u_req) begin
                  state_d = ST_USER;
               end else if (pend_q != '0) begin
                  state_d = ST_REF;
               end
            end
         end
         ST_USER: begin
            if (u_done) begin
               state_d = ST_IDLE;
            end
         end
         ST_REF: begin
            // One REF per grant, which lets user traffic interleave
            // between consecutive refreshes.
            if (r_ack) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Grants are flopped so they come straight off registers.
   always_comb begin
      u_gnt_d = (state_d == ST_USER);
      r_req_d = (state_d == ST_REF);
   end

   always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
      if (!mcb_rst_n) begin
         refi_cnt_q <= '0;
         pend_q     <= '0;
         ovf_q      <= 1'b0;
         state_q    <= ST_IDLE;
         u_gnt_q    <= 1'b0;
         r_req_q    <= 1'b0;
      end else if (!mcb_sclr_n) begin
         refi_cnt_q <= '0;
         pend_q     <= '0;
         ovf_q      <= 1'b0;
         state_q    <= ST_IDLE;
         u_gnt_q    <= 1'b0;
         r_req_q    <= 1'b0;
      end else begin
         refi_cnt_q <= refi_cnt_d;
         pend_q     <= pend_d;
         ovf_q      <= ovf_d;
         state_q    <= state_d;
         u_gnt_q    <= u_gnt_d;
         r_req_q    <= r_req_d;
      end
   end

   assign u_gnt      = u_gnt_q;
   assign r_req      = r_req_q;
   assign ref_urgent = urgent;
   assign ref_ovf    = ovf_q;
   assign pend_cnt   = pend_q;

endmodule

// File: tb/tb_mcb_ref_arb.sv
// Purpose     : bench for mcb_ref_arb with a behavioural refresh/ownership model and literal anchors.
// Latency     : outputs are observed 1 time unit after each rising edge; inputs change on falling edges.
// Backpressure: the stimulus honours u_req/u_gnt and r_req/r_ack handshakes, with occasional stray pulses.
module tb_mcb_ref_arb;

   localparam int REFI_CNT = 16;
   localparam int REFI_W   = 5;
   localparam int PEND_MAX = 8;
   localparam int PEND_W   = 4;
   localparam int URG_TH   = 6;

   localparam int OWN_NONE = 0;
   localparam int OWN_USER = 1;
   localparam int OWN_REF  = 2;

   logic              mcb_clk = 1'b0;
   logic              mcb_rst_n;
   logic              mcb_sclr_n;
   logic              i_ready;
   logic              u_req;
   logic              u_gnt;
   logic              u_done;
   logic              r_req;
   logic              r_ack;
   logic              ref_urgent;
   logic              ref_ovf;
   logic [PEND_W-1:0] pend_cnt;

   int errs   = 0;
   int checks = 0;
   int cyc    = 0;

   // Behavioural model state: cycles since init-ready, refreshes owed,
   // overflow seen, and who owns the sequencer.
   int m_run;
   int m_pend;
   bit m_ovf;
   int m_owner;
   int mo_old_pend;
   bit mo_tick;
   bit mo_ack;

   mcb_ref_arb #(
      .REFI_CNT (REFI_CNT),
      .REFI_W   (REFI_W),
      .PEND_MAX (PEND_MAX),
      .PEND_W   (PEND_W),
      .URG_TH   (URG_TH)
   ) dut (
      .mcb_clk    (mcb_clk),
      .mcb_rst_n  (mcb_rst_n),
      .mcb_sclr_n (mcb_sclr_n),
      .i_ready    (i_ready),
      .u_req      (u_req),
      .u_gnt      (u_gnt),
      .u_done     (u_done),
      .r_req      (r_req),
      .r_ack      (r_ack),
      .ref_urgent (ref_urgent),
      .ref_ovf    (ref_ovf),
      .pend_cnt   (pend_cnt)
   );

   always #5 mcb_clk = ~mcb_clk;

   function automatic void model_clear();
      m_run   = 0;
      m_pend  = 0;
      m_ovf   = 1'b0;
      m_owner = OWN_NONE;
   endfunction

   always @(posedge mcb_clk or negedge mcb_rst_n) begin
      if (!mcb_rst_n) begin
         model_clear();
      end else if (!mcb_sclr_n) begin
         model_clear();
      end else begin
         mo_old_pend = m_pend;
         mo_tick     = i_ready && ((m_run % REFI_CNT) == REFI_CNT - 1);
         mo_ack      = r_ack && (m_owner == OWN_REF);
         if (mo_tick && !mo_ack) begin
            if (m_pend == PEND_MAX) m_ovf = 1'b1;
            else m_pend = m_pend + 1;
         end else if (mo_ack && !mo_tick) begin
            m_pend = m_pend - 1;
         end
         m_run = i_ready ? m_run + 1 : 0;
         case (m_owner)
            OWN_NONE: begin
               if (i_ready) begin
                  if (mo_old_pend >= URG_TH) m_owner = OWN_REF;
                  else if (u_req) m_owner = OWN_USER;
                  else if (mo_old_pend != 0) m_owner = OWN_REF;
               end
            end
            OWN_USER: if (u_done) m_owner = OWN_NONE;
            default:  if (r_ack) m_owner = OWN_NONE;
         endcase
      end
   end

   task automatic model_compare();
      logic       eg, er, eu, eo;
      logic [3:0] ep;
      eg = (m_owner == OWN_USER);
      er = (m_owner == OWN_REF);
      eu = (m_pend >= URG_TH);
      eo = m_ovf;
      ep = m_pend[3:0];
      checks++;
      if ({u_gnt, r_req, ref_urgent, ref_ovf, pend_cnt} !== {eg, er, eu, eo, ep} || (u_gnt && r_req)) begin
         errs++;
         $display("FAIL model t=%0t: got u_gnt=%b r_req=%b urg=%b ovf=%b pend=%0d, expected u_gnt=%b r_req=%b urg=%b ovf=%b pend=%0d",
                  $time, u_gnt, r_req, ref_urgent, ref_ovf, pend_cnt, eg, er, eu, eo, ep);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge mcb_clk);
      #1;
      cyc++;
      model_compare();
   endtask

   task automatic step_to(input int n);
      while (cyc < n) step();
   endtask

   int ack_div;

   initial begin
      mcb_rst_n  = 1'b0;
      mcb_sclr_n = 1'b1;
      i_ready    = 1'b0;
      u_req      = 1'b0;
      u_done     = 1'b0;
      r_ack      = 1'b0;
      repeat (3) @(negedge mcb_clk);
      mcb_rst_n = 1'b1;
      step();
      chk("rst_u_gnt", u_gnt, 0);
      chk("rst_r_req", r_req, 0);
      chk("rst_pend", pend_cnt, 0);
      chk("rst_urgent", ref_urgent, 0);
      chk("rst_ovf", ref_ovf, 0);

      // First refresh after init: tick in cycle 15, r_req in cycle 17.
      @(negedge mcb_clk); i_ready = 1'b1; cyc = 0;
      step_to(15); chk("t1_pend15", pend_cnt, 0);
      step_to(16); chk("t1_pend16", pend_cnt, 1); chk("t1_rreq16", r_req, 0);
      step_to(17); chk("t1_rreq17", r_req, 1); chk("t1_ugnt17", u_gnt, 0);
      step_to(20); @(negedge mcb_clk); r_ack = 1'b1;
      step_to(21); chk("t1_pend21", pend_cnt, 0); chk("t1_rreq21", r_req, 0);
      @(negedge mcb_clk); r_ack = 1'b0;

      // Withhold r_ack: ticks at 31+16k, eighth fills the counter, ninth overflows.
      step_to(143); chk("sat_pend143", pend_cnt, 7); chk("sat_ovf143", ref_ovf, 0);
      step_to(144); chk("sat_pend144", pend_cnt, 8); chk("sat_urg144", ref_urgent, 1);
      step_to(159); chk("sat_ovf159", ref_ovf, 0);
      step_to(160); chk("sat_ovf160", ref_ovf, 1); chk("sat_pend160", pend_cnt, 8);
      step_to(200); chk("sat_ovf_sticky", ref_ovf, 1); chk("sat_rreq_held", r_req, 1);

      // Asynchronous reset while REF is granted: outputs drop at once.
      @(negedge mcb_clk); mcb_rst_n = 1'b0; i_ready = 1'b0;
      #1;
      chk("arst_rreq", r_req, 0); chk("arst_pend", pend_cnt, 0);
      chk("arst_ovf", ref_ovf, 0); chk("arst_urg", ref_urgent, 0); chk("arst_ugnt", u_gnt, 0);
      step(); step();
      @(negedge mcb_clk); mcb_rst_n = 1'b1;
      repeat (40) step();
      chk("arst_noready_pend", pend_cnt, 0); chk("arst_noready_rreq", r_req, 0);

      // Tick and r_ack together at pend 3, then stray pulses.
      @(negedge mcb_clk); i_ready = 1'b1; cyc = 0;
      step_to(16); chk("t5_pend16", pend_cnt, 1);
      step_to(48); chk("t5_pend48", pend_cnt, 3);
      step_to(63); @(negedge mcb_clk); r_ack = 1'b1;
      step_to(64); chk("t5_tick_ack_pend", pend_cnt, 3); chk("t5_rreq64", r_req, 0);
      @(negedge mcb_clk); r_ack = 1'b1; u_done = 1'b1;
      step_to(65); chk("t5_spur_pend", pend_cnt, 3); chk("t5_spur_rreq", r_req, 1); chk("t5_spur_ugnt", u_gnt, 0);
      @(negedge mcb_clk); r_ack = 1'b0; u_done = 1'b1;
      step_to(66); chk("t5_udone_in_ref", r_req, 1);
      @(negedge mcb_clk); u_done = 1'b0; mcb_sclr_n = 1'b0;
      step(); chk("sclr_ref_rreq", r_req, 0); chk("sclr_ref_pend", pend_cnt, 0);

      // User held: wins with debt pending, never preempted, then urgency wins.
      @(negedge mcb_clk); mcb_sclr_n = 1'b1; u_req = 1'b1; cyc = 0;
      step_to(17); chk("t2_ugnt17", u_gnt, 1); chk("t2_rreq17", r_req, 0);
      step_to(95); chk("t3_pend95", pend_cnt, 5); chk("t3_urg95", ref_urgent, 0);
      step_to(96); chk("t3_pend96", pend_cnt, 6); chk("t3_urg96", ref_urgent, 1); chk("t3_ugnt96", u_gnt, 1);
      step_to(100); @(negedge mcb_clk); u_done = 1'b1;
      step_to(101); chk("t3_ugnt101", u_gnt, 0); chk("t3_rreq101", r_req, 0);
      @(negedge mcb_clk); u_done = 1'b0;
      step_to(102); chk("t3_rreq102", r_req, 1); chk("t3_ugnt102", u_gnt, 0);
      @(negedge mcb_clk); r_ack = 1'b1;
      step_to(103); chk("t3_pend103", pend_cnt, 5); chk("t3_rreq103", r_req, 0);
      @(negedge mcb_clk); r_ack = 1'b0;
      step_to(104); chk("t2_ugnt104", u_gnt, 1); chk("t2_rreq104", r_req, 0);

      // Synchronous clear while USER is granted.
      @(negedge mcb_clk); mcb_sclr_n = 1'b0; i_ready = 1'b0; u_req = 1'b0;
      step_to(105); chk("sclr_ugnt", u_gnt, 0); chk("sclr_pend", pend_cnt, 0);
      @(negedge mcb_clk); mcb_sclr_n = 1'b1;
      repeat (40) step();
      chk("sclr_noready_pend", pend_cnt, 0);
      @(negedge mcb_clk); i_ready = 1'b1; cyc = 0;
      step_to(15); chk("sclr_restart15", pend_cnt, 0);
      step_to(16); chk("sclr_restart16", pend_cnt, 1);

      // Randomized traffic; second half starves r_ack to reach saturation.
      for (int n = 0; n < 6000; n++) begin
         ack_div = (n < 3000) ? 3 : 63;
         @(negedge mcb_clk);
         mcb_rst_n  = ($urandom_range(0, 1499) != 0);
         mcb_sclr_n = ($urandom_range(0, 999) != 0);
         if (i_ready) i_ready = ($urandom_range(0, 399) != 0);
         else         i_ready = ($urandom_range(0, 19) == 0);
         if (!u_req)      u_req = ($urandom_range(0, 7) == 0);
         else if (!u_gnt) u_req = ($urandom_range(0, 15) != 0);
         else             u_req = ($urandom_range(0, 3) != 0);
         u_done = u_gnt ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 39) == 0);
         r_ack  = r_req ? ($urandom_range(0, ack_div) == 0) : ($urandom_range(0, 39) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
